// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between display scan-out and a 4-deep host write FIFO.
// Latency: display address is combinational; rgb/de_o/hsync_o/vsync_o are one pixel period behind their inputs.
// Backpressure: wr_ready drops while 4 writes are queued; the display is never stalled. Double buffering: VGA_FB_ARBITER_DBUF_EN.

// Small generic FIFO with an occupancy count; DEPTH must equal 2**AW.
module vga_fb_fifo #(
  parameter int W     = 23,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [AW:0]  level,
  output logic         full,
  output logic         empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Entry storage; contents are only observed once counted in level, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a push and a pop in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
endmodule

module vga_fb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [2:0]  fifo_level,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  rgb,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  input  logic        swap_req,
  output logic        swap_done
);
  typedef enum logic [1:0] {IDLE, DISP_RD, HOST_WR} arb_state_t;

  arb_state_t  state;
  logic        front;
  logic        disp_slot;
  logic [14:0] disp_addr;
  logic [22:0] head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        unused_bits;

  // The 4x downscale drops the two low pixel bits.
  assign unused_bits = ^{pixel_x[1:0], pixel_y[1:0], swap_req};

  // 160x120 framebuffer scaled 4x: one word per 4x4 block of screen pixels.
  assign disp_addr = 15'(pixel_y[9:2]) * 15'd160 + 15'(pixel_x[9:2]);
  assign disp_slot = !p_tick && video_on;

  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && wr_ready;

  vga_fb_fifo #(.W(23), .DEPTH(4), .AW(2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({wr_addr, wr_data}),
    .pop   (fifo_pop),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Slot decision: display reads always win, host writes fill the remaining cycles.
  always_comb begin
    state = IDLE;
    if (disp_slot)        state = DISP_RD;
    else if (!fifo_empty) state = HOST_WR;
  end

  // Memory port drive; idle cycles hold the previous address and data.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    fifo_pop  = 1'b0;
    case (state)
      DISP_RD: mem_addr = {front, disp_addr};
      HOST_WR: begin
        fifo_pop  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {~front, head[22:8]};
        mem_wdata = head[7:0];
      end
      default: ;
    endcase
    // Reset quiets the port at once so no partial write escapes.
    if (rst) begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fifo_pop  = 1'b0;
    end
  end

  // Remember the last driven address/data for idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

  // Pixel-rate pipeline: RAM data and sync signals leave aligned, one pixel late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb     <= '0;
      de_o    <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else if (p_tick) begin
      rgb     <= video_on ? mem_rdata : 8'd0;
      de_o    <= video_on;
      hsync_o <= hsync_in;
      vsync_o <= vsync_in;
    end
  end

`ifdef VGA_FB_ARBITER_DBUF_EN
  logic pending;
  logic swap_evt;

  // A swap lands at the first pixel tick of the first blanking line; a request in that cycle counts.
  assign swap_evt = (pending || swap_req) && p_tick &&
                    (pixel_y == 10'd480) && (pixel_x == 10'd0);

  // Front-buffer select, pending request and one-cycle completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front     <= 1'b0;
      pending   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= swap_evt;
      if (swap_evt) begin
        front   <= ~front;
        pending <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
    end
  end
`else
  assign front     = 1'b0;
  assign swap_done = 1'b0;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: randomized and directed checks of vga_fb_arbiter against a queue-based model.
// Inputs change 1 time unit after each rising edge; outputs are sampled 4 units after the edge.
// The model tracks the write queue, buffer select and pixel pipeline from the behavioural rules.
module tb_vga_fb_arbiter;
  logic        clk, rst, p_tick, video_on, hsync_in, vsync_in;
  logic [9:0]  pixel_x, pixel_y;
  logic        wr_valid, wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic [2:0]  fifo_level;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata, rgb;
  logic        de_o, hsync_o, vsync_o, swap_req, swap_done;

`ifdef VGA_FB_ARBITER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .fifo_level(fifo_level), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb(rgb), .de_o(de_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .swap_req(swap_req), .swap_done(swap_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {logic [14:0] a; logic [7:0] d;} wr_t;
  wr_t         m_q[$];
  logic        m_front, m_pend, m_sd, m_de, m_hs, m_vs, m_acc;
  logic [15:0] m_addr_last;
  logic [7:0]  m_wd_last, m_rgb;
  logic        e_we, e_rdy;
  logic [15:0] e_addr;
  logic [7:0]  e_wd;
  logic [2:0]  e_lvl;

  function automatic logic [14:0] disp_of(input logic [9:0] x, input logic [9:0] y);
    int v;
    v = (int'(y) / 4) * 160 + int'(x) / 4;
    return v[14:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_front = 0; m_pend = 0; m_sd = 0; m_de = 0; m_hs = 0; m_vs = 0; m_acc = 0;
    m_addr_last = '0; m_wd_last = '0; m_rgb = '0;
  endtask

  task automatic model_comb();
    e_rdy = (m_q.size() < 4);
    e_lvl = 3'(m_q.size());
    e_wd  = m_wd_last;
    if (!p_tick && video_on) begin
      e_we = 0; e_addr = {m_front, disp_of(pixel_x, pixel_y)};
    end else if (m_q.size() > 0) begin
      e_we = 1; e_addr = {~m_front, m_q[0].a}; e_wd = m_q[0].d;
    end else begin
      e_we = 0; e_addr = m_addr_last;
    end
  endtask

  task automatic model_edge();
    wr_t w;
    bit  evt;
    m_acc = wr_valid && (m_q.size() < 4);
    if (e_we) void'(m_q.pop_front());
    if (m_acc) begin
      w.a = wr_addr; w.d = wr_data; m_q.push_back(w);
    end
    m_addr_last = e_addr;
    m_wd_last   = e_wd;
    if (p_tick) begin
      m_rgb = video_on ? mem_rdata : 8'd0;
      m_de = video_on; m_hs = hsync_in; m_vs = vsync_in;
    end
    evt  = DBUF && (m_pend || swap_req) && p_tick && pixel_y == 10'd480 && pixel_x == 10'd0;
    m_sd = evt;
    if (evt) begin
      m_front = ~m_front; m_pend = 0;
    end else if (DBUF && swap_req) begin
      m_pend = 1;
    end
  endtask

  task automatic settle();
    #3;
    model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      model_comb();
      model_edge();
    end
    #1;
  endtask

  task automatic new_write();
    wr_addr = ($urandom % 2) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
    wr_data = 8'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; p_tick = 0; video_on = 0; hsync_in = 0; vsync_in = 0; pixel_x = 0; pixel_y = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0; mem_rdata = 0; swap_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({mem_we, mem_addr, mem_wdata, rgb, de_o, hsync_o, vsync_o, swap_done} !== '0)
      $display("FAIL reset_outputs_in_rst: got we=%b addr=%h wd=%h rgb=%h de=%b hs=%b vs=%b sd=%b want all 0",
               mem_we, mem_addr, mem_wdata, rgb, de_o, hsync_o, vsync_o, swap_done);
    else n_pass++;
    rst = 0;
    settle();
    n_total++;
    if (wr_ready !== 1'b1 || fifo_level !== 3'd0)
      $display("FAIL reset_fifo: got ready=%b level=%0d want ready=1 level=0", wr_ready, fifo_level);
    else n_pass++;
    n_total++;
    if ({mem_we, mem_addr, mem_wdata, rgb, de_o, hsync_o, vsync_o, swap_done} !== '0)
      $display("FAIL reset_outputs_after: got we=%b addr=%h rgb=%h de=%b want all 0", mem_we, mem_addr, rgb, de_o);
    else n_pass++;
    tick();
    for (int i = 0; i < 20; i++) begin
      p_tick = i[0]; hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      mem_rdata = 8'($urandom); pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
      settle();
      n_total++;
      if (mem_we !== 1'b0 || rgb !== 8'd0)
        $display("FAIL blank_no_access: got we=%b rgb=%h want we=0 rgb=00", mem_we, rgb);
      else n_pass++;
      n_total++;
      if ({hsync_o, vsync_o, de_o} !== {m_hs, m_vs, m_de})
        $display("FAIL blank_sync: got hs/vs/de=%b%b%b want %b%b%b", hsync_o, vsync_o, de_o, m_hs, m_vs, m_de);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_display();
    video_on = 1; p_tick = 0; pixel_x = 10'd13; pixel_y = 10'd9; wr_valid = 0;
    settle();
    n_total++;
    if (mem_addr[14:0] !== 15'd323 || mem_we !== 1'b0 || mem_addr[15] !== m_front)
      $display("FAIL disp_addr_13_9: got addr=%h we=%b want addr[14:0]=323 we=0", mem_addr, mem_we);
    else n_pass++;
    tick();
    p_tick = 1; mem_rdata = 8'hA5;
    settle();
    tick();
    n_total++;
    if (rgb !== 8'hA5 || de_o !== 1'b1)
      $display("FAIL disp_rgb: got rgb=%h de=%b want rgb=a5 de=1", rgb, de_o);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      p_tick = ~p_tick; video_on = ($urandom % 4) != 0;
      pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); mem_rdata = 8'($urandom);
      settle();
      n_total++;
      if (mem_addr !== e_addr || mem_we !== e_we)
        $display("FAIL disp_rand_mem: got addr=%h we=%b want addr=%h we=%b", mem_addr, mem_we, e_addr, e_we);
      else n_pass++;
      n_total++;
      if ({rgb, de_o, hsync_o, vsync_o} !== {m_rgb, m_de, m_hs, m_vs})
        $display("FAIL disp_rand_video: got rgb=%h de/hs/vs=%b%b%b want rgb=%h %b%b%b",
                 rgb, de_o, hsync_o, vsync_o, m_rgb, m_de, m_hs, m_vs);
      else n_pass++;
      if (de_o === 1'b0) begin
        n_total++;
        if (rgb !== 8'd0) $display("FAIL rgb_blank: got rgb=%h with de_o=0 want 00", rgb);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    video_on = 1; p_tick = 0; pixel_x = 10'd40; pixel_y = 10'd40;
    settle();
    n_total++;
    if (fifo_level !== 3'd0) $display("FAIL b2b_start_level: got %0d want 0", fifo_level);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 15'(100 + i); wr_data = 8'(16 + i);
      settle();
      n_total++;
      if (wr_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", i, wr_ready);
      else n_pass++;
      tick();
    end
    wr_addr = 15'd104; wr_data = 8'h14;
    settle();
    n_total++;
    if (wr_ready !== 1'b0 || fifo_level !== 3'd4)
      $display("FAIL b2b_full: got ready=%b level=%0d want ready=0 level=4", wr_ready, fifo_level);
    else n_pass++;
    tick();
    p_tick = 1;
    settle();
    n_total++;
    if (mem_we !== 1'b1 || mem_addr !== {~m_front, 15'd100} || mem_wdata !== 8'h10 || wr_ready !== 1'b0)
      $display("FAIL b2b_first_pop: got we=%b addr=%h wd=%h ready=%b want we=1 addr[14:0]=100 wd=10 ready=0",
               mem_we, mem_addr, mem_wdata, wr_ready);
    else n_pass++;
    tick();
    p_tick = 0;
    settle();
    n_total++;
    if (wr_ready !== 1'b1 || fifo_level !== 3'd3 || mem_we !== 1'b0)
      $display("FAIL b2b_after_pop: got ready=%b level=%0d we=%b want ready=1 level=3 we=0", wr_ready, fifo_level, mem_we);
    else n_pass++;
    tick();
    wr_valid = 0;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      p_tick = ~p_tick;
      settle();
      if (mem_we === 1'b1) pops++;
      n_total++;
      if (mem_we !== e_we || (e_we && (mem_addr !== e_addr || mem_wdata !== e_wd)))
        $display("FAIL b2b_drain: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                 mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
      else n_pass++;
      tick();
    end
    settle();
    n_total++;
    if (pops !== 4 || fifo_level !== 3'd0)
      $display("FAIL b2b_pop_count: got pops=%0d level=%0d want pops=4 level=0", pops, fifo_level);
    else n_pass++;
  endtask

  task automatic test_stream();
    video_on = 0; wr_valid = 1; wr_addr = 15'h7FFF; wr_data = 8'($urandom);
    for (int i = 0; i < 12; i++) begin
      p_tick = ~p_tick;
      settle();
      n_total++;
      if (fifo_level !== e_lvl || fifo_level > 3'd1 || wr_ready !== 1'b1)
        $display("FAIL stream_level: got level=%0d ready=%b want level=%0d ready=1", fifo_level, wr_ready, e_lvl);
      else n_pass++;
      n_total++;
      if (mem_we !== e_we || (e_we && (mem_addr !== e_addr || mem_wdata !== e_wd)))
        $display("FAIL stream_write: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                 mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
      else n_pass++;
      tick();
      if (m_acc) new_write();
    end
    wr_valid = 0;
    repeat (2) begin
      p_tick = ~p_tick;
      settle();
      tick();
    end
  endtask

  task automatic test_random();
    wr_valid = 0;
    for (int i = 0; i < 200; i++) begin
      p_tick = ~p_tick; video_on = ($urandom % 4) != 0;
      pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 479));
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); mem_rdata = 8'($urandom);
      if (!wr_valid) begin
        wr_valid = 1'($urandom);
        new_write();
      end
      settle();
      n_total++;
      if (mem_we !== e_we || mem_addr !== e_addr || (e_we && mem_wdata !== e_wd))
        $display("FAIL rand_mem: got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                 mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wd);
      else n_pass++;
      n_total++;
      if (wr_ready !== e_rdy || fifo_level !== e_lvl || rgb !== m_rgb || de_o !== m_de)
        $display("FAIL rand_state: got ready=%b level=%0d rgb=%h de=%b want ready=%b level=%0d rgb=%h de=%b",
                 wr_ready, fifo_level, rgb, de_o, e_rdy, e_lvl, m_rgb, m_de);
      else n_pass++;
      tick();
      if (m_acc) wr_valid = 0;
    end
    wr_valid = 0; video_on = 0;
    repeat (8) begin
      p_tick = ~p_tick;
      settle();
      tick();
    end
    settle();
    n_total++;
    if (fifo_level !== 3'd0) $display("FAIL rand_drain: got level=%0d want 0", fifo_level);
    else n_pass++;
  endtask

  task automatic test_swap();
    int  ys[13]  = '{100, 100, 101, 200, 300, 480, 480, 480, 480, 480, 481, 480, 10};
    int  xs[13]  = '{20, 20, 20, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0};
    bit  pts[13] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    bit  rqs[13] = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    int  pulses = 0;
    for (int i = 0; i < 13; i++) begin
      pixel_y = 10'(ys[i]); pixel_x = 10'(xs[i]); p_tick = pts[i]; swap_req = rqs[i];
      video_on = (i == 8); wr_valid = (i == 8);
      new_write();
      settle();
      if (swap_done === 1'b1) pulses++;
      n_total++;
      if (swap_done !== m_sd || mem_we !== e_we || mem_addr !== e_addr)
        $display("FAIL swap_row_%0d: got sd=%b we=%b addr=%h want sd=%b we=%b addr=%h",
                 i, swap_done, mem_we, mem_addr, m_sd, e_we, e_addr);
      else n_pass++;
      if (i == 8) begin
        n_total++;
        if (mem_addr[15] !== DBUF) $display("FAIL swap_read_sel: got %b want %b", mem_addr[15], DBUF);
        else n_pass++;
      end
      if (i == 9) begin
        n_total++;
        if (mem_we !== 1'b1 || mem_addr[15] !== !DBUF)
          $display("FAIL swap_write_sel: got we=%b sel=%b want we=1 sel=%b", mem_we, mem_addr[15], !DBUF);
        else n_pass++;
      end
      tick();
    end
    swap_req = 0; wr_valid = 0; video_on = 0;
    n_total++;
    if (pulses !== (DBUF ? 2 : 0))
      $display("FAIL swap_count: got %0d pulses want %0d", pulses, DBUF ? 2 : 0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    video_on = 1; p_tick = 0; wr_valid = 1; pixel_x = 10'd8; pixel_y = 10'd8;
    for (int i = 0; i < 3; i++) begin
      new_write();
      settle();
      tick();
    end
    wr_valid = 0;
    settle();
    n_total++;
    if (fifo_level !== 3'd3) $display("FAIL mid_fill: got level=%0d want 3", fifo_level);
    else n_pass++;
    #1 rst = 1;
    #1;
    model_reset();
    n_total++;
    if (fifo_level !== 3'd0 || mem_we !== 1'b0)
      $display("FAIL mid_reset: got level=%0d we=%b want level=0 we=0", fifo_level, mem_we);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    video_on = 0;
    for (int i = 0; i < 10; i++) begin
      p_tick = i[0];
      settle();
      n_total++;
      if (mem_we !== 1'b0 || fifo_level !== 3'd0)
        $display("FAIL mid_after: got we=%b level=%0d want we=0 level=0", mem_we, fifo_level);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_display();
    test_back_to_back();
    test_stream();
    test_random();
    test_swap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
